// File: rtl/tx_dispatch_pkg.sv
// tx_dispatch_pkg: shared frame layout, FSM state and channel-select types.
package tx_dispatch_pkg;

  localparam int unsigned FRAME_W  = 40;
  localparam int unsigned ID_MSB   = 39;
  localparam int unsigned ID_LSB   = 32;
  localparam logic [7:0]  ID_BCAST = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StWait
  } state_e;

  typedef enum logic [1:0] {
    Ch01,
    Ch02,
    ChBoth
  } ch_e;

  // Saturating add of a small increment onto an 8-bit counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/tx_dispatch_fifo.sv
// tx_dispatch_fifo: synchronous first-word-fall-through FIFO of command frames.
// Callers gate wr_en with !full and rd_en with !empty.
module tx_dispatch_fifo
  import tx_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [FRAME_W-1:0] wr_d,
  input  logic               rd_en,
  output logic [FRAME_W-1:0] rd_d,
  output logic [CW-1:0]      count
);

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;

  assign rd_d  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Storage array; data needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_d;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tx_dispatch.sv
// tx_dispatch: buffers command frames and routes each, in order, to the UART TX
// selected by its destination ID byte. Build option TX_DISPATCH_BCAST_EN turns
// ID 8'hFF into a broadcast to both channels; otherwise 8'hFF is dropped.
module tx_dispatch
  import tx_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  ID01  = 8'h01,
  parameter logic [7:0]  ID02  = 8'h02
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        reg_f,
  input  logic [39:0] reg_d,
  output logic        reg_full,
  output logic        id01_f,
  output logic [39:0] id01_d,
  input  logic        id01_busy,
  output logic        id02_f,
  output logic [39:0] id02_d,
  input  logic        id02_busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic [CW-1:0]      count, count_nx;
  logic [FRAME_W-1:0] head;
  logic [7:0]         head_id;
  logic               full, empty, wr_en, wr_drop;
  logic               go01, go02, go_both, unk_drop, pop, sel_busy;

  state_e             state_q;
  ch_e                ch_q;
  logic               id01_f_q, id02_f_q, full_q;
  logic [FRAME_W-1:0] id01_d_q, id02_d_q;
  logic [7:0]         drop_q;

  // Full decision uses the registered count; a same-cycle pop frees nothing.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = reg_f & ~full & ~sys_rst;
  assign wr_drop = reg_f & full;
  assign head_id = head[ID_MSB:ID_LSB];

  tx_dispatch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .wr_en (wr_en),
    .wr_d  (reg_d),
    .rd_en (pop),
    .rd_d  (head),
    .count (count)
  );

  // Head-of-queue decode: dispatch when the target is free, drop unknown IDs.
  always_comb begin
    go01     = 1'b0;
    go02     = 1'b0;
    go_both  = 1'b0;
    unk_drop = 1'b0;
    if (state_q == StIdle && !empty) begin
      if (head_id == ID01) begin
        go01 = ~id01_busy;
      end else if (head_id == ID02) begin
        go02 = ~id02_busy;
`ifdef TX_DISPATCH_BCAST_EN
      end else if (head_id == ID_BCAST) begin
        go_both = ~id01_busy & ~id02_busy;
`endif
      end else begin
        unk_drop = 1'b1;
      end
    end
    pop = go01 | go02 | go_both | unk_drop;
  end

  // Busy of whichever channel(s) the last dispatch went to.
  always_comb begin
    sel_busy = 1'b0;
    unique case (ch_q)
      Ch01:    sel_busy = id01_busy;
      Ch02:    sel_busy = id02_busy;
      default: sel_busy = id01_busy | id02_busy;
    endcase
  end

  // Occupancy after this cycle, used to register the full flag.
  always_comb begin
    count_nx = count + CW'(wr_en) - CW'(pop);
  end

  // Dispatch FSM with registered start pulses, frame outputs and status.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      ch_q     <= Ch01;
      id01_f_q <= 1'b0;
      id02_f_q <= 1'b0;
      id01_d_q <= '0;
      id02_d_q <= '0;
      full_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      id01_f_q <= go01 | go_both;
      id02_f_q <= go02 | go_both;
      if (go01 | go_both) id01_d_q <= head;
      if (go02 | go_both) id02_d_q <= head;
      full_q <= (count_nx == CW'(DEPTH));
      drop_q <= sat_add8(drop_q, {1'b0, wr_drop} + {1'b0, unk_drop});
      unique case (state_q)
        StIdle: begin
          if (go01 | go02 | go_both) begin
            state_q <= StGuard;
            ch_q    <= go_both ? ChBoth : (go02 ? Ch02 : Ch01);
          end
        end
        // One cycle for the TX to raise busy before it is looked at.
        StGuard: state_q <= StWait;
        StWait: begin
          if (!sel_busy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign id01_f   = id01_f_q;
  assign id02_f   = id02_f_q;
  assign id01_d   = id01_d_q;
  assign id02_d   = id02_d_q;
  assign reg_full = full_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_tx_dispatch.sv
// tb_tx_dispatch: scoreboard bench for tx_dispatch. Expected dispatches are
// queued in order as frames are issued; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tx_dispatch;

  localparam int unsigned DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst, reg_f, reg_full;
  logic [39:0] reg_d, id01_d, id02_d;
  logic        id01_f, id02_f, id01_busy, id02_busy;
  logic [7:0]  drop_cnt;

  always #5 sys_clk = ~sys_clk;

  tx_dispatch #(
    .DEPTH (DEPTH),
    .ID01  (8'h01),
    .ID02  (8'h02)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .reg_f     (reg_f),
    .reg_d     (reg_d),
    .reg_full  (reg_full),
    .id01_f    (id01_f),
    .id01_d    (id01_d),
    .id01_busy (id01_busy),
    .id02_f    (id02_f),
    .id02_d    (id02_d),
    .id02_busy (id02_busy),
    .drop_cnt  (drop_cnt)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Expected dispatch: ch 1 = TX01, 2 = TX02, 3 = both; at = required cycle or -1.
  typedef struct {
    int          ch;
    logic [39:0] d;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  // UART TX stand-ins: after a start pulse stay busy for a random 0..6 cycles.
  logic force01 = 1'b0, force02 = 1'b0;
  int   cnt01 = 0, cnt02 = 0;
  always @(posedge sys_clk) begin
    if (id01_f) cnt01 <= $urandom_range(6, 0);
    else if (cnt01 > 0) cnt01 <= cnt01 - 1;
    if (id02_f) cnt02 <= $urandom_range(6, 0);
    else if (cnt02 > 0) cnt02 <= cnt02 - 1;
  end
  assign id01_busy = force01 | (cnt01 != 0);
  assign id02_busy = force02 | (cnt02 != 0);

  // Monitor: every start pulse must match the oldest expected dispatch.
  int   pulses = 0, last_pulse = -1, m_ch;
  exp_t m_e;
  always @(negedge sys_clk) begin
    if (id01_f || id02_f) begin
      m_ch = (id01_f ? 1 : 0) + (id02_f ? 2 : 0);
      pulses++;
      if (last_pulse >= 0) check("pulse_spacing_ge3", 64'(cyc - last_pulse >= 3), 64'd1);
      last_pulse = cyc;
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: got ch %0d d01 %h d02 %h, expected no pulse",
                 m_ch, id01_d, id02_d);
      end else begin
        m_e = sb_q.pop_front();
        check("pulse_channel", 64'(m_ch), 64'(m_e.ch));
        if (m_ch == 1 || m_ch == 3) check("id01_d", {24'd0, id01_d}, {24'd0, m_e.d});
        if (m_ch >= 2) check("id02_d", {24'd0, id02_d}, {24'd0, m_e.d});
        if (m_e.at >= 0) check("pulse_cycle", 64'(cyc), 64'(m_e.at));
      end
    end
  end

  // Reference: IDs 01/02 go to their channel, FF is broadcast only when enabled,
  // anything else produces no dispatch.
  function automatic int route(input logic [39:0] d);
    logic [7:0] id;
    id = d[39:32];
    if (id == 8'h01) return 1;
    if (id == 8'h02) return 2;
`ifdef TX_DISPATCH_BCAST_EN
    if (id == 8'hFF) return 3;
`endif
    return 0;
  endfunction

  int mdl_drop = 0;
  task automatic expect_frame(input logic [39:0] d, input int at);
    exp_t e;
    e.ch = route(d);
    e.d  = d;
    e.at = at;
    if (e.ch == 0) mdl_drop++;
    else sb_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    if (n > 0) begin
      repeat (n) @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input logic [39:0] d);
    reg_f = 1'b1;
    reg_d = d;
    tick();
    reg_f = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb_q.size() != 0 || cnt01 != 0 || cnt02 != 0) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) begin
      n_chk++;
      $display("FAIL %s_timeout: got %0d pending dispatches, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    tick(6);
  endtask

  function automatic int exp_drop();
    return (mdl_drop > 255) ? 255 : mdl_drop;
  endfunction

  int          p0, occ, sent, base, t;
  logic [39:0] d;

  initial begin
    // Reset with a strobe held high: nothing may be stored.
    sys_rst = 1'b1;
    reg_f   = 1'b1;
    reg_d   = 40'h01_AAAAAAAA;
    tick(3);
    sys_rst = 1'b0;
    reg_f   = 1'b0;
    @(negedge sys_clk);
    check("rst_id01_f", 64'(id01_f), 64'd0);
    check("rst_id02_f", 64'(id02_f), 64'd0);
    check("rst_id01_d", {24'd0, id01_d}, 64'd0);
    check("rst_id02_d", {24'd0, id02_d}, 64'd0);
    check("rst_reg_full", 64'(reg_full), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    tick(8);
    check("rst_no_dispatch", 64'(pulses), 64'd0);

    // Basic routing with exact N+2 latency.
    expect_frame(40'h01_DEADBEEF, cyc + 2);
    send(40'h01_DEADBEEF);
    drain("route01");
    expect_frame(40'h02_CAFEF00D, cyc + 2);
    send(40'h02_CAFEF00D);
    drain("route02");
    check("id01_d_held", {24'd0, id01_d}, 64'h01_DEADBEEF);

    // Head-of-line blocking behind a busy TX01.
    force01 = 1'b1;
    p0 = pulses;
    expect_frame(40'h01_11111111, -1);
    send(40'h01_11111111);
    expect_frame(40'h02_22222222, -1);
    send(40'h02_22222222);
    tick(10);
    check("hol_blocked", 64'(pulses), 64'(p0));
    force01 = 1'b0;
    drain("hol");
    check("hol_released", 64'(pulses), 64'(p0 + 2));

    // Overflow: both busy, six back-to-back strobes into a depth-4 FIFO.
    force01 = 1'b1;
    force02 = 1'b1;
    occ = 0;
    for (int i = 0; i < 6; i++) begin
      d = {($urandom_range(1, 0) != 0) ? 8'h02 : 8'h01, 32'($urandom)};
      if (occ < int'(DEPTH)) begin
        expect_frame(d, -1);
        occ++;
      end else begin
        mdl_drop++;
      end
      send(d);
      check("ovf_reg_full", 64'(reg_full), 64'(occ == int'(DEPTH)));
    end
    tick();
    check("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drop()));
    force01 = 1'b0;
    force02 = 1'b0;
    drain("overflow");
    check("ovf_full_cleared", 64'(reg_full), 64'd0);

    // Unknown ID is dropped; the next valid frame still goes out.
    p0 = pulses;
    expect_frame(40'h07_00000000, -1);
    send(40'h07_00000000);
    expect_frame(40'h02_0BADF00D, -1);
    send(40'h02_0BADF00D);
    drain("unknown");
    check("unk_one_pulse", 64'(pulses), 64'(p0 + 1));
    check("unk_drop_cnt", 64'(drop_cnt), 64'(exp_drop()));

    // Broadcast ID.
    p0 = pulses;
`ifdef TX_DISPATCH_BCAST_EN
    force02 = 1'b1;
    expect_frame(40'hFF_12345678, -1);
    send(40'hFF_12345678);
    tick(8);
    check("bcast_waits", 64'(pulses), 64'(p0));
    force02 = 1'b0;
    drain("bcast");
    check("bcast_one_event", 64'(pulses), 64'(p0 + 1));
`else
    expect_frame(40'hFF_12345678, -1);
    send(40'hFF_12345678);
    drain("bcast");
    check("bcast_no_pulse", 64'(pulses), 64'(p0));
`endif
    check("bcast_drop_cnt", 64'(drop_cnt), 64'(exp_drop()));

    // Random traffic, flow-controlled so the FIFO can never overflow.
    sent = 0;
    base = pulses;
    for (int i = 0; i < 150; i++) begin
      t = 0;
      while ((sent - (pulses - base)) >= int'(DEPTH) && t < 200) begin
        tick();
        t++;
      end
      d = {($urandom_range(1, 0) != 0) ? 8'h02 : 8'h01, 32'($urandom)};
      expect_frame(d, -1);
      send(d);
      sent++;
      tick($urandom_range(2, 0));
    end
    drain("random");
    check("rand_all_sent", 64'(pulses - base), 64'(sent));
    check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop()));

    // Saturation: enough unknown IDs to push the counter past 255.
    for (int i = 0; i < 260; i++) expect_frame({8'h33, 32'(i)}, -1);
    for (int i = 0; i < 260; i++) send({8'h33, 32'(i)});
    tick(6);
    check("drop_cnt_saturated", 64'(drop_cnt), 64'(exp_drop()));

    // Mid-operation reset flushes queued frames and clears outputs.
    force01 = 1'b1;
    force02 = 1'b1;
    send(40'h01_55555555);
    send(40'h02_66666666);
    tick(2);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    mdl_drop = 0;
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("mid_rst_id01_d", {24'd0, id01_d}, 64'd0);
    check("mid_rst_id02_d", {24'd0, id02_d}, 64'd0);
    check("mid_rst_reg_full", 64'(reg_full), 64'd0);
    p0 = pulses;
    force01 = 1'b0;
    force02 = 1'b0;
    tick(12);
    check("mid_rst_flushed", 64'(pulses), 64'(p0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/tx_dispatch.md
Name: tx_dispatch

Overview:
- Transmit-side counterpart of the sensor receive aggregator.
- Accepts 40-bit command frames from the register/cache module and buffers them in a small in-order FIFO.
- Routes each frame, by its destination ID byte, to the matching per-sensor UART transmitter, using a start-pulse/busy handshake.
- Sits between the register module and the UART TX modules for sensor ID 01 and ID 02.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- ID01, 8'h01: destination ID routed to channel 01.
- ID02, 8'h02: destination ID routed to channel 02.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- reg_f  in  1  one-cycle frame-valid strobe from the register module.
- reg_d  in  40  frame; [39:32] destination ID, [31:0] payload.
- reg_full  out  1  FIFO full; frames strobed while high are dropped.
- id01_f  out  1  one-cycle start pulse to UART TX 01.
- id01_d  out  40  frame to TX 01; held stable until the next id01_f.
- id01_busy  in  1  TX 01 busy; high while shifting out a frame.
- id02_f  out  1  start pulse to UART TX 02.
- id02_d  out  40  frame to TX 02; held stable until the next id02_f.
- id02_busy  in  1  TX 02 busy.
- drop_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Reset: every output register clears on the first sys_clk edge with sys_rst high.
  - id01_f, id02_f, reg_full = 0; id01_d, id02_d = 0; drop_cnt = 0.
  - FIFO pointers and count = 0; FSM = IDLE.
- Reset mid-operation: a frame already handed to a UART TX is not aborted; the rest of the block clears as above.
- FIFO write: reg_f=1 and count<DEPTH stores reg_d.
  - reg_f=1 when count==DEPTH drops the frame and increments drop_cnt.
  - The full decision uses the registered count; a pop in the same cycle does not free space for that write.
- reg_full = (count==DEPTH), registered.
- No bypass: a write into an empty FIFO is visible to the FSM one cycle later.
- Strict in-order dispatch; a busy target blocks all later frames (head-of-line).
- FSM states:
  - IDLE: if FIFO non-empty, decode head[39:32].
    - ID01 with id01_busy=0: load id01_d, pulse id01_f for 1 cycle, pop, go to GUARD(ch=01).
    - ID02 with id02_busy=0: same on channel 02.
    - Target busy: stay in IDLE; the head is retained.
    - Any other ID: pop, increment drop_cnt, stay in IDLE; no pulse.
  - GUARD: one cycle, giving the TX time to raise busy; then go to WAIT.
  - WAIT: stay while the selected channel's busy=1; return to IDLE when it is 0.
    - A TX that never raises busy costs exactly the GUARD cycle.
- Latency: reg_f in cycle N into an empty FIFO with an idle target gives idxx_f high in cycle N+2.
- Minimum spacing between consecutive start pulses: 3 cycles (pulse, GUARD, WAIT seeing busy=0).
- drop_cnt saturates at 8'hFF.
  - An overflow drop and an unknown-ID drop in the same cycle add 2, saturating.
- Simultaneous write and pop: both take effect; count is unchanged.

Optional Feature:
- Macro: TX_DISPATCH_BCAST_EN.
- Defined:
  - ID 8'hFF is a broadcast.
  - In IDLE it waits until id01_busy=0 and id02_busy=0.
  - It then loads both data outputs, pulses id01_f and id02_f in the same cycle, and pops.
  - WAIT then returns to IDLE only when both busy signals are 0.
- Not defined: 8'hFF is an unknown ID and is dropped and counted.

Decomposition:
- Package tx_dispatch_pkg:
  - FRAME_W=40, ID_MSB=39, ID_LSB=32, ID_BCAST=8'hFF.
  - FSM state enum {IDLE, GUARD, WAIT}.
  - Channel-select encoding {CH01, CH02, CHBOTH}.
- Sub-module tx_dispatch_fifo: synchronous FIFO, width FRAME_W, depth DEPTH.
  - Ports: wr_en, wr_d, rd_en, rd_d (head, first-word-fall-through), count.

Test Plan:
- Reset behaviour: drive reg_f=1 during sys_rst=1 -> no FIFO write; all outputs 0 the cycle after reset releases.
- Basic route: reg_d=40'h01_DEADBEEF in cycle N, both TX idle -> id01_f=1 in N+2 only, id01_d=40'h01DEADBEEF, id02_f stays 0; repeat with ID 02 -> id02_f.
- Head-of-line: hold id01_busy=1, send 01-frame then 02-frame -> no pulses while busy; release id01_busy -> id01_f, then id02_f at least 3 cycles later.
- Overflow: hold both busy=1, strobe 6 frames with DEPTH=4 -> reg_full=1 after the 4th; drop_cnt=2; the 4 stored frames later emerge in order.
- Unknown ID: frame 40'h07_00000000 -> no pulse, drop_cnt +1; the next valid frame still dispatches normally.
- Broadcast, built with TX_DISPATCH_BCAST_EN: 40'hFF_12345678 with id02_busy=1 -> wait; on release, id01_f and id02_f both pulse in the same cycle. Without the macro the same frame increments drop_cnt.
